// File: rtl/dco_ctrl_pkg.sv
// Shared definitions for the DCO row/column code path: FSM states,
// default word geometry and the reset code.
package dco_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, STEP = 2'd1, SETTLE = 2'd2} state_t;

  localparam int DEF_WORD_W = 8;
  localparam int DEF_ROW_W  = 4;
  localparam int RST_CODE   = 0;
endpackage

// File: rtl/dco_row_col_enc_if.sv
// Tuning-word handshake plus the row/column code bundle presented to the
// capacitor-bank code register.
interface dco_row_col_enc_if
  import dco_ctrl_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int ROW_W  = DEF_ROW_W,
  parameter int SIZE   = 1 << ROW_W
);
  logic [WORD_W-1:0] tune_word;
  logic              tune_valid;
  logic              tune_ready;
  logic [SIZE-1:0]   r_all_nxt;
  logic [SIZE-1:0]   row_nxt;
  logic [SIZE-1:0]   col_nxt;
  logic              en;
  logic [WORD_W-1:0] cur_code;

  modport master (
    output tune_word, tune_valid,
    input  tune_ready, r_all_nxt, row_nxt, col_nxt, en, cur_code
  );

  modport slave (
    input  tune_word, tune_valid,
    output tune_ready, r_all_nxt, row_nxt, col_nxt, en, cur_code
  );
endinterface

// File: rtl/therm_enc.sv
// Binary-to-thermometer decoder: bit i of therm is set when i < k.
module therm_enc #(
  parameter int ROW_W = 4,
  parameter int SIZE  = 1 << ROW_W
) (
  input  logic [ROW_W-1:0] k,
  output logic [SIZE-1:0]  therm
);
  for (genvar i = 0; i < SIZE; i++) begin : g_bit
    assign therm[i] = (ROW_W'(i) < k);
  end
endmodule

// File: rtl/dco_row_col_enc.sv
// Tuning word -> row/column thermometer codes with slew-limited ramping.
// Build option: define DCO_SLEW_LIMIT_EN to step by MAX_STEP; otherwise one jump per word.
module dco_row_col_enc
  import dco_ctrl_pkg::*;
#(
  parameter int WORD_W     = DEF_WORD_W,
  parameter int ROW_W      = DEF_ROW_W,
  parameter int SIZE       = 1 << ROW_W,
  parameter int MAX_STEP   = 16,
  parameter int SETTLE_CYC = 4
) (
  input logic               clk,
  input logic               rst,
  dco_row_col_enc_if.slave  bus
);
`ifdef DCO_SLEW_LIMIT_EN
  localparam int LIM_I = MAX_STEP;
`else
  localparam int LIM_I = 1 << WORD_W;
`endif
  localparam int LIM_C = (LIM_I > (1 << WORD_W)) ? (1 << WORD_W) : LIM_I;
  localparam logic [WORD_W:0] STEP_LIM = (WORD_W+1)'(LIM_C);
  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  state_t state, nxt_state;
  logic [WORD_W-1:0] target, cur_q, step_code;
  logic [CNT_W-1:0]  cnt;
  logic [SIZE-1:0]   r_all_q, row_q, col_q, r_all_d, col_d;
  logic              en_q, ready_q, load, accept;
  logic signed [WORD_W:0] diff;
  logic [WORD_W:0]   mag, stp, sum;

  assign accept = (state == IDLE) && bus.tune_valid && ready_q;

  // Signed difference one bit wider than the code, so the clamped step
  // can never carry past either end of the code range.
  always_comb begin
    nxt_state = state;
    load      = 1'b0;
    diff      = $signed({1'b0, target}) - $signed({1'b0, cur_q});
    mag       = diff[WORD_W] ? $unsigned(-diff) : $unsigned(diff);
    stp       = (mag > STEP_LIM) ? STEP_LIM : mag;
    sum       = diff[WORD_W] ? ({1'b0, cur_q} - stp) : ({1'b0, cur_q} + stp);
    step_code = sum[WORD_W-1:0];
    case (state)
      IDLE:    if (accept) nxt_state = STEP;
      STEP: begin
        if (diff == '0) nxt_state = IDLE;
        else begin
          load      = 1'b1;
          nxt_state = SETTLE;
        end
      end
      SETTLE:  if (cnt == '0) nxt_state = STEP;
      default: nxt_state = IDLE;
    endcase
  end

  therm_enc #(.ROW_W(ROW_W), .SIZE(SIZE)) u_rall (
    .k     (step_code[WORD_W-1:ROW_W]),
    .therm (r_all_d)
  );

  therm_enc #(.ROW_W(ROW_W), .SIZE(SIZE)) u_col (
    .k     (step_code[ROW_W-1:0]),
    .therm (col_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      target  <= WORD_W'(RST_CODE);
      cur_q   <= WORD_W'(RST_CODE);
      cnt     <= '0;
      r_all_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      en_q    <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state   <= nxt_state;
      ready_q <= (nxt_state == IDLE);
      en_q    <= load;
      if (accept) target <= bus.tune_word;
      if (load) begin
        cur_q   <= step_code;
        r_all_q <= r_all_d;
        row_q   <= SIZE'(1) << step_code[WORD_W-1:ROW_W];
        col_q   <= col_d;
        cnt     <= CNT_W'(SETTLE_CYC - 1);
      end else if (state == SETTLE && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign bus.tune_ready = ready_q;
  assign bus.en         = en_q;
  assign bus.cur_code   = cur_q;
  assign bus.r_all_nxt  = r_all_q;
  assign bus.row_nxt    = row_q;
  assign bus.col_nxt    = col_q;
endmodule

// File: tb/tb_dco_row_col_enc.sv
// Self-checking bench for dco_row_col_enc: table of test-plan moves,
// hand-written reset/hold sequences, then random moves against a ramp model.
module tb_dco_row_col_enc;
  localparam int WORD_W = 8, ROW_W = 4, SIZE = 16, MAX_STEP = 16, SETTLE_CYC = 4;
`ifdef DCO_SLEW_LIMIT_EN
  localparam int LIM = MAX_STEP;
`else
  localparam int LIM = 1 << WORD_W;
`endif
  localparam int BOUND = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dco_row_col_enc_if #(.WORD_W(WORD_W), .ROW_W(ROW_W), .SIZE(SIZE)) bus_if ();

  dco_row_col_enc #(
    .WORD_W(WORD_W), .ROW_W(ROW_W), .SIZE(SIZE),
    .MAX_STEP(MAX_STEP), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    int word;
    int rall;
    int row;
    int col;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  int model_cur = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Encoding computed from cap counts: r full rows, k caps in the partial row.
  task automatic chk_enc(input string name);
    int c, r, k;
    c = int'(bus_if.cur_code);
    r = c / SIZE;
    k = c % SIZE;
    chk({name, "_rall"}, int'(bus_if.r_all_nxt), (1 << r) - 1);
    chk({name, "_row"},  int'(bus_if.row_nxt),   1 << r);
    chk({name, "_col"},  int'(bus_if.col_nxt),   (1 << k) - 1);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_en"},    int'(bus_if.en), 0);
    chk({name, "_code"},  int'(bus_if.cur_code), 0);
    chk({name, "_rall"},  int'(bus_if.r_all_nxt), 0);
    chk({name, "_row"},   int'(bus_if.row_nxt), 0);
    chk({name, "_col"},   int'(bus_if.col_nxt), 0);
    chk({name, "_ready"}, int'(bus_if.tune_ready), 0);
  endtask

  function automatic int npulses(input int from, input int to);
    int d;
    d = (to > from) ? to - from : from - to;
    return (d + LIM - 1) / LIM;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus_if.tune_valid = 1'b0;
    bus_if.tune_word  = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", int'(bus_if.tune_ready), 1);
    model_cur = 0;
  endtask

  // Apply one word, watch the ramp cycle by cycle, compare to the model.
  task automatic move(input int word);
    int cyc, prev, ready_cyc, c, s;
    int pc[$];
    int codes[$];
    int exp_codes[$];
    cyc = 0;
    while (!bus_if.tune_ready && cyc < BOUND) begin
      @(negedge clk);
      cyc++;
    end
    chk("ready_wait", int'(bus_if.tune_ready), 1);
    bus_if.tune_word  = WORD_W'(word);
    bus_if.tune_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.tune_valid = 1'b0;
    chk("ready_drop", int'(bus_if.tune_ready), 0);
    cyc = 0;
    prev = model_cur;
    ready_cyc = -1;
    while (cyc < BOUND) begin
      if (bus_if.en) begin
        pc.push_back(cyc);
        codes.push_back(int'(bus_if.cur_code));
        chk_enc("pulse_enc");
      end else if (int'(bus_if.cur_code) != prev) begin
        chk("code_without_en", int'(bus_if.cur_code), prev);
      end
      prev = int'(bus_if.cur_code);
      if (bus_if.tune_ready) begin
        ready_cyc = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    c = model_cur;
    while (c != word) begin
      s = (word > c) ? word - c : c - word;
      if (s > LIM) s = LIM;
      c = (word > c) ? c + s : c - s;
      exp_codes.push_back(c);
    end
    chk("pulse_count", pc.size(), exp_codes.size());
    for (int i = 0; i < pc.size() && i < exp_codes.size(); i++)
      chk("pulse_code", codes[i], exp_codes[i]);
    if (pc.size() > 0) begin
      chk("first_pulse_cyc", pc[0], 1);
      for (int i = 1; i < pc.size(); i++)
        chk("pulse_spacing", pc[i] - pc[i-1], SETTLE_CYC + 1);
      chk("ready_return", ready_cyc, pc[pc.size()-1] + SETTLE_CYC + 1);
    end else begin
      chk("ready_return_nop", ready_cyc, 1);
    end
    chk("final_code", int'(bus_if.cur_code), word);
    model_cur = word;
  endtask

  initial begin
    vec_t tbl[5];
    int cyc, np, want;
    tbl[0] = '{40,  'h0003, 'h0004, 'h00FF};
    tbl[1] = '{35,  'h0003, 'h0004, 'h0007};
    tbl[2] = '{35,  'h0003, 'h0004, 'h0007};
    tbl[3] = '{255, 'h7FFF, 'h8000, 'h7FFF};
    tbl[4] = '{0,   'h0000, 'h0001, 'h0000};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_en", int'(bus_if.en), 0);
      chk("hold_code", int'(bus_if.cur_code), 0);
    end

    for (int i = 0; i < 5; i++) begin
      move(tbl[i].word);
      chk("tbl_rall", int'(bus_if.r_all_nxt), tbl[i].rall);
      chk("tbl_row",  int'(bus_if.row_nxt),   tbl[i].row);
      chk("tbl_col",  int'(bus_if.col_nxt),   tbl[i].col);
    end

    // Word 100 held on the bus during a ramp to 200 must wait its turn.
    bus_if.tune_word  = 8'd200;
    bus_if.tune_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.tune_word = 8'd100;
    np = 0;
    cyc = 0;
    while (!bus_if.tune_ready && cyc < BOUND) begin
      if (bus_if.en) np++;
      @(negedge clk);
      cyc++;
    end
    chk("held_ready", int'(bus_if.tune_ready), 1);
    chk("held_pulses", np, npulses(model_cur, 200));
    chk("held_code", int'(bus_if.cur_code), 200);
    model_cur = 200;
    move(100);

    // Reset in the middle of a 0 -> 200 ramp.
    do_reset();
    want = (npulses(0, 200) >= 2) ? 2 : 1;
    bus_if.tune_word  = 8'd200;
    bus_if.tune_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.tune_valid = 1'b0;
    np = 0;
    cyc = 0;
    while (cyc < BOUND) begin
      if (bus_if.en) np++;
      if (np == want) break;
      @(negedge clk);
      cyc++;
    end
    chk("midramp_pulses", np, want);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("midramp_rst");
    rst = 1'b0;
    @(negedge clk);
    chk("midramp_ready", int'(bus_if.tune_ready), 1);
    np = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus_if.en) np++;
      @(negedge clk);
    end
    chk("midramp_no_en", np, 0);
    chk("midramp_code", int'(bus_if.cur_code), 0);
    model_cur = 0;

    for (int i = 0; i < 15; i++)
      move(int'($urandom_range(0, 255)));
    move(255);
    move(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
